multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 28 ++
 rtl/multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for the multicycle core.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [31:0] Ins;
  logic        BrTaken;
  logic        MemReady;
  logic        MemReq;
  logic        MemWe;
  logic        IorD;
  logic        IrWe;
  logic        PcWe;
  logic [1:0]  PcSel;
  logic        RegWe;
  logic [1:0]  WbSel;
  logic        AluSrcB;
  logic        Illegal;
  logic [2:0]  State;

  modport master (
    input  Ins, BrTaken, MemReady,
    output MemReq, MemWe, IorD, IrWe, PcWe, PcSel, RegWe, WbSel, AluSrcB, Illegal, State
  );

  modport slave (
    output Ins, BrTaken, MemReady,
    input  MemReq, MemWe, IorD, IrWe, PcWe, PcSel, RegWe, WbSel, AluSrcB, Illegal, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB plus a sticky TRAP.
// Outputs are decoded combinationally from the state register and Ins.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam int C_LOAD   = 0;
  localparam int C_MISC   = 1;
  localparam int C_OPIMM  = 2;
  localparam int C_AUIPC  = 3;
  localparam int C_STORE  = 4;
  localparam int C_OP     = 5;
  localparam int C_LUI    = 6;
  localparam int C_BRANCH = 7;
  localparam int C_JALR   = 8;
  localparam int C_JAL    = 9;
  localparam int C_SYSTEM = 10;
  localparam int NCLS     = 11;

  // Opcode table indexed by class number (entry gi sits at bits gi*7 +: 7).
  localparam logic [NCLS*7-1:0] OPC_TABLE = {
    7'b1110011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111, 7'b0110011,
    7'b0100011, 7'b0010111, 7'b0010011, 7'b0001111, 7'b0000011
  };

  state_t          state_reg;
  logic            run_reg;
  logic [NCLS-1:0] cls;
  logic            legal;
  logic            rd_nz;
  logic            unused_ins;

  generate
    for (genvar gi = 0; gi < NCLS; gi++) begin : g_dec
      assign cls[gi] = (bus.Ins[6:0] == OPC_TABLE[gi*7 +: 7]);
    end
  endgenerate

  assign legal      = |cls;
  assign rd_nz      = (bus.Ins[11:7] != 5'd0);
  assign unused_ins = ^bus.Ins[31:12];

  // run_reg holds off the first request until one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      run_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        FETCH:  if (run_reg && bus.MemReady) state_reg <= DECODE;
        DECODE: state_reg <= legal ? EXEC : TRAP;
        EXEC: begin
          if (cls[C_BRANCH] || cls[C_MISC] || cls[C_SYSTEM])
            state_reg <= FETCH;
          else if (cls[C_LOAD] || cls[C_STORE])
            state_reg <= MEM;
          else if (cls[C_OP] || cls[C_OPIMM] || cls[C_LUI] || cls[C_AUIPC] ||
                   cls[C_JAL] || cls[C_JALR])
            state_reg <= WB;
          else
            state_reg <= TRAP;
        end
        MEM:    if (bus.MemReady) state_reg <= cls[C_STORE] ? FETCH : WB;
        WB:     state_reg <= FETCH;
        TRAP:   state_reg <= TRAP;
        default: state_reg <= TRAP;
      endcase
    end
  end

  always_comb begin
    bus.MemReq  = 1'b0;
    bus.MemWe   = 1'b0;
    bus.IorD    = 1'b0;
    bus.IrWe    = 1'b0;
    bus.PcWe    = 1'b0;
    bus.PcSel   = 2'b00;
    bus.RegWe   = 1'b0;
    bus.WbSel   = 2'b00;
    bus.AluSrcB = 1'b0;
    bus.Illegal = (state_reg == TRAP);
    bus.State   = state_reg;
    if (run_reg) begin
      case (state_reg)
        FETCH: begin
          bus.MemReq = 1'b1;
          bus.IrWe   = bus.MemReady;
        end
        EXEC: begin
          bus.AluSrcB = cls[C_OPIMM] | cls[C_LOAD] | cls[C_STORE] | cls[C_JALR];
          if (cls[C_BRANCH]) begin
            bus.PcWe  = 1'b1;
            bus.PcSel = {1'b0, bus.BrTaken};
          end else if (cls[C_MISC] || cls[C_SYSTEM]) begin
            bus.PcWe = 1'b1;
          end
        end
        MEM: begin
          bus.MemReq = 1'b1;
          bus.IorD   = 1'b1;
          bus.MemWe  = cls[C_STORE];
          // A store retires on the completing edge, so PC advances only once.
          bus.PcWe   = cls[C_STORE] & bus.MemReady;
        end
        WB: begin
          bus.RegWe = rd_nz;
          bus.PcWe  = 1'b1;
          if (cls[C_LOAD])
            bus.WbSel = 2'b01;
          else if (cls[C_JAL] || cls[C_JALR])
            bus.WbSel = 2'b10;
          else if (cls[C_LUI])
            bus.WbSel = 2'b11;
          if (cls[C_JAL])
            bus.PcSel = 2'b01;
          else if (cls[C_JALR])
            bus.PcSel = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes, memory waits,
// trap and reset behaviour, checking all outputs packed into one vector.
module tb_multicycle_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: state, MemReq, MemWe, IorD, IrWe, PcWe, PcSel, RegWe, WbSel, AluSrcB, Illegal
  function automatic logic [14:0] ex(logic [2:0] st, logic req, logic we, logic iord,
                                     logic irwe, logic pcwe, logic [1:0] pcsel, logic regwe,
                                     logic [1:0] wbsel, logic srcb, logic ill);
    return {req, we, iord, irwe, pcwe, pcsel, regwe, wbsel, srcb, ill, st};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.MemReq, bus.MemWe, bus.IorD, bus.IrWe, bus.PcWe, bus.PcSel, bus.RegWe,
            bus.WbSel, bus.AluSrcB, bus.Illegal, bus.State};
  endfunction

  task automatic chk(input string tag, input logic [14:0] e);
    logic [14:0] o;
    #1;
    o = obs();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic st(input string tag, input logic [14:0] e);
    chk(tag, e);
    tick();
  endtask

  localparam logic [14:0] QUIET = 15'd0;
  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A103;
  localparam logic [31:0] I_SW   = 32'h0020_A223;
  localparam logic [31:0] I_BEQ  = 32'h0000_0463;
  localparam logic [31:0] I_JALR = 32'h0000_8067;
  localparam logic [31:0] I_JAL  = 32'h0080_00EF;
  localparam logic [31:0] I_LUI  = 32'h1234_51B7;
  localparam logic [31:0] I_ECAL = 32'h0000_0073;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;
  localparam logic [31:0] I_BAD2 = 32'h0050_0090;

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.Ins     = I_ADDI;
    bus.BrTaken = 1'b0;
    bus.MemReady = 1'b1;

    #2;
    chk("rst_async", QUIET);
    tick();
    chk("rst_hold", QUIET);
    rst_n = 1'b1;
    chk("rel_noreq", QUIET);
    tick();

    // ADDI x1,x0,5 with zero-wait memory: 0,1,2,4,0
    st("addi_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("addi_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("addi_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    st("addi_w", ex(4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 0));

    // LW with three wait cycles in MEM
    bus.Ins = I_LW;
    st("lw_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("lw_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    bus.MemReady = 1'b0;
    st("lw_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    for (int i = 0; i < 3; i++)
      st($sformatf("lw_mwait%0d", i), ex(3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    bus.MemReady = 1'b1;
    st("lw_mdone", ex(3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("lw_w", ex(4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 0, 0));

    // SW with one fetch wait; PC written on the MEM completion edge
    bus.Ins = I_SW;
    bus.MemReady = 1'b0;
    st("sw_fwait", ex(0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    bus.MemReady = 1'b1;
    st("sw_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("sw_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("sw_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    st("sw_m", ex(3, 1, 1, 1, 0, 1, 2'b00, 0, 2'b00, 0, 0));

    // BEQ taken then not taken
    bus.Ins = I_BEQ;
    bus.BrTaken = 1'b1;
    st("beq1_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("beq1_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("beq1_e", ex(2, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 0));
    bus.BrTaken = 1'b0;
    st("beq0_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("beq0_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("beq0_e", ex(2, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0));

    // JALR x0
    bus.Ins = I_JALR;
    st("jalr_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("jalr_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("jalr_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    st("jalr_w", ex(4, 0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 0, 0));

    // JAL x1
    bus.Ins = I_JAL;
    st("jal_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("jal_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("jal_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("jal_w", ex(4, 0, 0, 0, 0, 1, 2'b01, 1, 2'b10, 0, 0));

    // LUI x3
    bus.Ins = I_LUI;
    st("lui_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("lui_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("lui_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("lui_w", ex(4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b11, 0, 0));

    // ECALL as a no-op
    bus.Ins = I_ECAL;
    st("ecall_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("ecall_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("ecall_e", ex(2, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0));

    // Reset during a waiting fetch drops MemReq immediately
    bus.Ins = I_ADDI;
    bus.MemReady = 1'b0;
    chk("rstf_pre", ex(0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    rst_n = 1'b0;
    chk("rstf_drop", QUIET);
    bus.MemReady = 1'b1;
    tick();
    chk("rstf_held", QUIET);
    rst_n = 1'b1;
    chk("rstf_rel", QUIET);
    tick();
    st("rstf_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("rstf_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("rstf_e", ex(2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    st("rstf_w", ex(4, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 0));

    // Illegal opcode traps and stays quiet
    bus.Ins = I_BAD;
    st("bad_f", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    st("bad_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    for (int i = 0; i < 20; i++) begin
      bus.MemReady = i[0];
      bus.BrTaken  = i[1];
      st($sformatf("trap%0d", i), ex(5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    end
    rst_n = 1'b0;
    chk("trap_rst", QUIET);
    tick();
    rst_n = 1'b1;
    bus.MemReady = 1'b1;
    tick();
    st("trap_refetch", ex(0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));

    // Ins[1:0] != 11 is illegal
    bus.Ins = I_BAD2;
    st("bad2_d", ex(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    st("bad2_t", ex(5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
